// File: rtl/sram_read_cache_pkg.sv
// -----------------------------------------------------------------------------
// sram_read_cache_pkg
// Shared definitions for the SRAM read cache: the controller state encoding
// and helpers that split a byte address into cache index and tag fields.
// The helpers take the index width as an argument so that one package
// serves every RANGE value; callers size-cast the result to the field width.
// -----------------------------------------------------------------------------
package sram_read_cache_pkg;

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_LOOKUP,
        ST_BUS_READ,
        ST_BUS_WRITE,
        ST_READY,
        ST_RELEASE
    } state_e;

    // Word index: address bits [iw+1:2], zero-extended to 32 bits.
    function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                               input int unsigned iw);
        return (addr >> 2) & ((32'd1 << iw) - 32'd1);
    endfunction

    // Tag: address bits [31:iw+2], right-aligned.
    function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                             input int unsigned iw);
        return addr >> (iw + 2);
    endfunction

endpackage

// File: rtl/sram_read_cache_line_ram.sv
// -----------------------------------------------------------------------------
// cache_line_ram
// Single-port line store for the read cache. Synchronous write and
// synchronous read (one-cycle latency); a read at the address being written
// returns the old contents. The controller never depends on that case.
// Ports:
//   clk_i    clock
//   we_i     write enable
//   addr_i   line index
//   wdata_i  line contents to write {valid, tag, data}
//   rdata_o  registered line contents read at the previous edge
// -----------------------------------------------------------------------------
module cache_line_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int W     = 55
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_read_cache.sv
// -----------------------------------------------------------------------------
// sram_read_cache
// Direct-mapped, write-through cache with one 32-bit word per line, sitting
// between the CPU data bus and the SRAM interface. Read hits complete two
// edges after the request is sampled; read misses and all writes are passed
// downstream with the same request/ready handshake, and both allocate the line.
// After reset the whole line store is cleared one index per cycle before any
// request is accepted.
// Ports:
//   i_clock, i_reset          clock, synchronous active-high reset
//   i_request, i_rw           CPU request (held until o_ready), 1 = write
//   i_address, i_wdata        CPU byte address (word aligned) and write data
//   o_rdata, o_ready          read data and one-cycle completion pulse
//   o_bus_request, o_bus_rw   downstream request and direction
//   o_bus_address             downstream word-aligned byte address
//   o_bus_wdata               downstream write data
//   i_bus_rdata, i_bus_ready  downstream read data and completion
// -----------------------------------------------------------------------------
module sram_read_cache
    import sram_read_cache_pkg::*;
#(
    parameter int RANGE = 256
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic        i_rw,
    input  logic [31:0] i_address,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic        o_bus_request,
    output logic        o_bus_rw,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_wdata,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_ready
);

    localparam int IW = $clog2(RANGE);
    localparam int TW = 30 - IW;
    localparam int LW = 1 + TW + 32;

    state_e        state_q, state_d;
    logic [IW-1:0] flush_idx_q, flush_idx_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          rw_q, rw_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          ready_q, ready_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_rw_q, bus_rw_d;

    logic          ram_we;
    logic [IW-1:0] ram_addr;
    logic [LW-1:0] ram_wdata;
    logic [LW-1:0] ram_rdata;

    logic [IW-1:0] in_idx;
    logic [IW-1:0] lat_idx;
    logic [TW-1:0] lat_tag;
    logic          line_valid;
    logic [TW-1:0] line_tag;
    logic [31:0]   line_data;

    assign in_idx     = IW'(addr_index(i_address, IW));
    assign lat_idx    = IW'(addr_index(addr_q, IW));
    assign lat_tag    = TW'(addr_tag(addr_q, IW));
    assign line_valid = ram_rdata[LW-1];
    assign line_tag   = ram_rdata[LW-2:32];
    assign line_data  = ram_rdata[31:0];

    cache_line_ram #(
        .DEPTH (RANGE),
        .AW    (IW),
        .W     (LW)
    ) u_line_ram (
        .clk_i   (i_clock),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= ST_FLUSH;
            flush_idx_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rw_q        <= 1'b0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_rw_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_idx_q <= flush_idx_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rw_q        <= rw_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            bus_req_q   <= bus_req_d;
            bus_rw_q    <= bus_rw_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_idx_d = flush_idx_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rw_d        = rw_q;
        rdata_d     = rdata_q;
        ready_d     = ready_q;
        bus_req_d   = bus_req_q;
        bus_rw_d    = bus_rw_q;
        ram_we      = 1'b0;
        ram_addr    = lat_idx;
        ram_wdata   = '0;

        case (state_q)
            ST_FLUSH: begin
                // Invalidate one line per cycle; the index wraps back to 0
                // on the last line so a later reset starts clean.
                ram_we      = 1'b1;
                ram_addr    = flush_idx_q;
                flush_idx_d = flush_idx_q + 1'b1;
                if (flush_idx_q == IW'(RANGE - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // Read the line for the incoming address now so the tag
                // is available in LOOKUP.
                ram_addr = in_idx;
                if (i_request) begin
                    addr_d  = {i_address[31:2], 2'b00};
                    wdata_d = i_wdata;
                    rw_d    = i_rw;
                    if (i_rw) begin
                        bus_req_d = 1'b1;
                        bus_rw_d  = 1'b1;
                        state_d   = ST_BUS_WRITE;
                    end else begin
                        state_d = ST_LOOKUP;
                    end
                end
            end
            ST_LOOKUP: begin
                if (line_valid && (line_tag == lat_tag)) begin
                    rdata_d = line_data;
                    ready_d = 1'b1;
                    state_d = ST_READY;
                end else begin
                    bus_req_d = 1'b1;
                    bus_rw_d  = 1'b0;
                    state_d   = ST_BUS_READ;
                end
            end
            ST_BUS_READ: begin
                if (i_bus_ready) begin
                    bus_req_d = 1'b0;
                    ram_we    = 1'b1;
                    ram_wdata = {1'b1, lat_tag, i_bus_rdata};
                    rdata_d   = i_bus_rdata;
                    ready_d   = 1'b1;
                    state_d   = ST_READY;
                end
            end
            ST_BUS_WRITE: begin
                // Write-through with allocate: the line always mirrors SRAM.
                if (i_bus_ready) begin
                    bus_req_d = 1'b0;
                    ram_we    = 1'b1;
                    ram_wdata = {1'b1, lat_tag, wdata_q};
                    ready_d   = 1'b1;
                    state_d   = ST_READY;
                end
            end
            ST_READY: begin
                ready_d = 1'b0;
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                // A request still held high must not be serviced again.
                if (!i_request) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_FLUSH;
            end
        endcase
    end

    assign o_rdata       = rdata_q;
    assign o_ready       = ready_q;
    assign o_bus_request = bus_req_q;
    assign o_bus_rw      = bus_rw_q;
    assign o_bus_address = addr_q;
    assign o_bus_wdata   = wdata_q;

endmodule

// File: tb/tb_sram_read_cache.sv
module tb_sram_read_cache;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_request;
    logic        i_rw;
    logic [31:0] i_address;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_ready;
    logic        o_bus_request;
    logic        o_bus_rw;
    logic [31:0] o_bus_address;
    logic [31:0] o_bus_wdata;
    logic [31:0] i_bus_rdata;
    logic        i_bus_ready;

    sram_read_cache #(.RANGE(256)) dut (
        .i_clock       (clk),
        .i_reset       (i_reset),
        .i_request     (i_request),
        .i_rw          (i_rw),
        .i_address     (i_address),
        .i_wdata       (i_wdata),
        .o_rdata       (o_rdata),
        .o_ready       (o_ready),
        .o_bus_request (o_bus_request),
        .o_bus_rw      (o_bus_rw),
        .o_bus_address (o_bus_address),
        .o_bus_wdata   (o_bus_wdata),
        .i_bus_rdata   (i_bus_rdata),
        .i_bus_ready   (i_bus_ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        rw;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] last_rd = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Downstream SRAM model: completes each request after 6 cycles and
    // holds ready until the request drops.
    logic [31:0] mem [logic [31:0]];
    int          bus_txn = 0;
    int          bus_cnt = 0;
    logic        last_bus_rw;
    logic [31:0] last_bus_addr;
    logic [31:0] last_bus_wdata;

    always @(posedge clk) begin
        #1;
        if (!o_bus_request) begin
            i_bus_ready = 1'b0;
            bus_cnt     = 0;
        end else if (!i_bus_ready) begin
            bus_cnt++;
            if (bus_cnt >= 6) begin
                i_bus_ready    = 1'b1;
                bus_txn++;
                last_bus_rw    = o_bus_rw;
                last_bus_addr  = o_bus_address;
                last_bus_wdata = o_bus_wdata;
                if (o_bus_rw) begin
                    mem[o_bus_address] = o_bus_wdata;
                end else begin
                    i_bus_rdata = mem.exists(o_bus_address) ? mem[o_bus_address] : 32'h0;
                end
            end
        end
    end

    // Scoreboard monitor: every o_ready pulse must match the oldest expectation.
    int ready_pulses = 0;
    always @(negedge clk) begin : mon
        exp_t e;
        if (o_ready) begin
            ready_pulses++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ready: got o_ready=1 with rdata 0x%08h, expected no completion", o_rdata);
            end else begin
                e = exp_q.pop_front();
                chk(e.rw ? "rdata_hold_on_write" : "rdata", o_rdata, e.data);
            end
        end
    end

    task automatic wait_ready(input string nm, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!o_ready && n < 300);
        chk({nm, "_ready_seen"}, {31'b0, o_ready}, 32'd1);
    endtask

    task automatic do_req(input string nm, input logic rw, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input int exp_bus, input int exp_lat, input int hold);
        int n;
        int b0;
        int extra;
        exp_t e;
        e.rw   = rw;
        e.data = rw ? last_rd : exp_rd;
        if (!rw) last_rd = exp_rd;
        exp_q.push_back(e);
        b0 = bus_txn;
        @(negedge clk);
        i_request = 1'b1;
        i_rw      = rw;
        i_address = addr;
        i_wdata   = wd;
        wait_ready(nm, n);
        if (exp_lat >= 0) chk({nm, "_latency"}, n, exp_lat);
        extra = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (o_ready || o_bus_request) extra++;
        end
        if (hold > 0) chk({nm, "_no_repeat"}, extra, 0);
        @(negedge clk);
        i_request = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk({nm, "_bus_txns"}, bus_txn - b0, exp_bus);
    endtask

    // Reset, then hold a read of 0x100 from the first cycle: nothing may
    // happen during the 256 flush cycles and the miss goes out 2 edges later.
    task automatic reset_and_read(input string nm);
        int n;
        int b0;
        int rp0;
        exp_t e;
        @(negedge clk);
        i_reset   = 1'b1;
        i_request = 1'b0;
        @(posedge clk); #1;
        chk({nm, "_rst_bus_req"}, {31'b0, o_bus_request}, 32'd0);
        chk({nm, "_rst_ready"}, {31'b0, o_ready}, 32'd0);
        @(posedge clk); #1;
        chk({nm, "_rst_outputs"}, o_rdata | o_bus_address | o_bus_wdata | {30'b0, o_bus_rw, o_ready}, 32'd0);
        e.rw = 1'b0;
        e.data = 32'hDEADBEEF;
        last_rd = 32'hDEADBEEF;
        exp_q.push_back(e);
        b0  = bus_txn;
        rp0 = ready_pulses;
        @(negedge clk);
        i_reset   = 1'b0;
        i_request = 1'b1;
        i_rw      = 1'b0;
        i_address = 32'h100;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!o_bus_request && n < 400);
        chk({nm, "_flush_edges_to_miss"}, n, 258);
        chk({nm, "_no_ready_in_flush"}, ready_pulses - rp0, 0);
        chk({nm, "_miss_addr"}, o_bus_address, 32'h100);
        wait_ready(nm, n);
        @(negedge clk);
        i_request = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk({nm, "_bus_txns"}, bus_txn - b0, 1);
        chk({nm, "_bus_dir"}, {31'b0, last_bus_rw}, 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        i_reset     = 1'b1;
        i_request   = 1'b0;
        i_rw        = 1'b0;
        i_address   = 32'h0;
        i_wdata     = 32'h0;
        i_bus_rdata = 32'h0;
        i_bus_ready = 1'b0;
        mem[32'h100] = 32'hDEADBEEF;
        mem[32'h004] = 32'h0000000A;
        mem[32'h404] = 32'h0000000B;
        mem[32'h300] = 32'h33333333;
        mem[32'h800] = 32'h55555555;

        reset_and_read("first_miss");

        // Repeat read (byte offset ignored) hits: 2 edges, no bus activity.
        do_req("hit_0x100", 1'b0, 32'h103, 32'h0, 32'hDEADBEEF, 0, 2, 0);

        // Write-through, then the read hits the allocated line.
        do_req("write_0x200", 1'b1, 32'h200, 32'h12345678, 32'h0, 1, -1, 0);
        chk("write_bus_addr", last_bus_addr, 32'h200);
        chk("write_bus_wdata", last_bus_wdata, 32'h12345678);
        chk("write_bus_dir", {31'b0, last_bus_rw}, 32'd1);
        do_req("hit_0x200", 1'b0, 32'h200, 32'h0, 32'h12345678, 0, 2, 0);

        // Aliasing lines evict each other.
        do_req("alias_a1", 1'b0, 32'h004, 32'h0, 32'h0000000A, 1, -1, 0);
        do_req("alias_b",  1'b0, 32'h404, 32'h0, 32'h0000000B, 1, -1, 0);
        do_req("alias_a2", 1'b0, 32'h004, 32'h0, 32'h0000000A, 1, -1, 0);

        // Request held 20 cycles past completion: single pulse, single txn.
        do_req("hold_0x300", 1'b0, 32'h300, 32'h0, 32'h33333333, 1, -1, 20);

        // Reset while a miss is outstanding: no completion, full re-flush.
        @(negedge clk);
        i_request = 1'b1;
        i_rw      = 1'b0;
        i_address = 32'h800;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!o_bus_request && n < 50);
        chk("midmiss_bus_req", {31'b0, o_bus_request}, 32'd1);
        reset_and_read("after_reset");

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
